icache_mem_responder: RTL and testbench

ICACHE_MEM_RESPONDER -- requirements
Module: icache_mem_responder

---
 rtl/icache_mem_responder_pkg.sv | 16 +
 rtl/imem_word_ram.sv | 32 +++
 rtl/icache_mem_responder.sv | 151 +++++++++++++++
 tb/tb_icache_mem_responder.sv | 232 +++++++++++++++++++++++
 4 files changed

// File: rtl/icache_mem_responder_pkg.sv
// Shared types and line geometry for the instruction-cache memory responder.
// The cache side imports this too, so line/word widths stay in one place.
package icache_mem_responder_pkg;

    localparam int unsigned LINE_W     = 128;
    localparam int unsigned WORD_W     = 32;
    localparam int unsigned LINE_BYTES = 16;
    localparam int unsigned BEATS      = LINE_W / WORD_W;

    typedef enum logic [1:0] {
        StIdle,
        StWait,
        StFetch
    } state_e;

endpackage

// File: rtl/imem_word_ram.sv
// Word store: one synchronous read port and one write port, contents not reset.
// A read and a write to the same word on the same edge return the old contents.
module imem_word_ram
    import icache_mem_responder_pkg::*;
#(
    parameter int unsigned Words = 4096,
    parameter int unsigned AddrW = (Words > 1) ? $clog2(Words) : 1
) (
    input  logic              clk_i,
    input  logic              re_i,
    input  logic [AddrW-1:0]  raddr_i,
    output logic [WORD_W-1:0] rdata_o,
    input  logic              we_i,
    input  logic [AddrW-1:0]  waddr_i,
    input  logic [WORD_W-1:0] wdata_i
);

    logic [WORD_W-1:0] mem_q [Words];
    logic [WORD_W-1:0] rdata_q;

    always_ff @(posedge clk_i) begin
        if (we_i) begin
            mem_q[waddr_i] <= wdata_i;
        end
        if (re_i) begin
            rdata_q <= mem_q[raddr_i];
        end
    end

    assign rdata_o = rdata_q;

endmodule

// File: rtl/icache_mem_responder.sv
// Returns a 16-byte line as four word beats after a programmable wait,
// with abort-and-restart on a new request and a side loader port for the store.
module icache_mem_responder
    import icache_mem_responder_pkg::*;
#(
    parameter int unsigned MEM_WORDS = 4096,
    parameter int unsigned LATENCY   = 2
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              Icache_valid_req_i,
    input  logic [31:0]       Icache_addr_i,
    output logic              mem_ready_o,
    output logic [LINE_W-1:0] mem_data_o,
    output logic              mem_err_o,
    input  logic              ld_we_i,
    input  logic [31:0]       ld_addr_i,
    input  logic [WORD_W-1:0] ld_data_i,
    output logic              busy_o
);

    localparam int unsigned AddrW    = (MEM_WORDS > 1) ? $clog2(MEM_WORDS) : 1;
    localparam logic [30:0] MemWords = 31'(MEM_WORDS);
    localparam logic [3:0]  LastWait = 4'((LATENCY > 0) ? LATENCY - 1 : 0);

    state_e            state_q, state_d;
    logic [27:0]       line_q, line_d;
    logic [1:0]        beat_q, beat_d;
    logic [3:0]        wait_q, wait_d;
    logic [95:0]       buf_q, buf_d;
    logic              err_acc_q, err_acc_d;
    logic [LINE_W-1:0] data_q, data_d;
    logic              ready_q, ready_d;
    logic              err_q, err_d;
    logic              rd_oor_q;

    logic [30:0]       rd_idx, ld_idx;
    logic              rd_en, rd_oor, ld_ok;
    logic [WORD_W-1:0] ram_rdata, beat_word;
    logic              unused_bits;

    // The store is read one edge ahead of each beat capture, so the address
    // comes from next-state and the word is ready when the beat is taken.
    // 31-bit index: a carry past 2^30 lands out of range instead of aliasing.
    assign rd_idx = {1'b0, line_d, 2'b00} + {29'd0, beat_d};
    assign rd_oor = rd_idx >= MemWords;
    assign rd_en  = state_d == StFetch;
    assign ld_idx = {1'b0, ld_addr_i[31:2]};
    assign ld_ok  = ld_we_i && (ld_idx < MemWords);

    assign unused_bits = ^{Icache_addr_i[3:0], ld_addr_i[1:0], rd_idx[30:AddrW],
                           ld_idx[30:AddrW]};

    imem_word_ram #(
        .Words(MEM_WORDS),
        .AddrW(AddrW)
    ) u_ram (
        .clk_i  (clk),
        .re_i   (rd_en && !rd_oor),
        .raddr_i(rd_idx[AddrW-1:0]),
        .rdata_o(ram_rdata),
        .we_i   (ld_ok),
        .waddr_i(ld_idx[AddrW-1:0]),
        .wdata_i(ld_data_i)
    );

    assign beat_word = rd_oor_q ? '0 : ram_rdata;

    always_comb begin
        state_d   = state_q;
        line_d    = line_q;
        beat_d    = beat_q;
        wait_d    = wait_q;
        buf_d     = buf_q;
        err_acc_d = err_acc_q;
        data_d    = data_q;
        ready_d   = 1'b0;
        err_d     = 1'b0;

        unique case (state_q)
            StWait: begin
                if (wait_q == LastWait) begin
                    state_d = StFetch;
                end else begin
                    wait_d = wait_q + 4'd1;
                end
            end
            StFetch: begin
                beat_d    = beat_q + 2'd1;
                err_acc_d = ((beat_q == 2'd0) ? 1'b0 : err_acc_q) | rd_oor_q;
                unique case (beat_q)
                    2'd0: buf_d[31:0]  = beat_word;
                    2'd1: buf_d[63:32] = beat_word;
                    2'd2: buf_d[95:64] = beat_word;
                    default: begin
                        data_d  = {beat_word, buf_q};
                        ready_d = 1'b1;
                        err_d   = err_acc_q | rd_oor_q;
                        state_d = StIdle;
                    end
                endcase
            end
            default: ;
        endcase

        // A new request always wins, even over the beat that would complete a line.
        if (Icache_valid_req_i) begin
            line_d  = Icache_addr_i[31:4];
            beat_d  = 2'd0;
            wait_d  = 4'd0;
            state_d = (LATENCY == 0) ? StFetch : StWait;
            data_d  = data_q;
            ready_d = 1'b0;
            err_d   = 1'b0;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q   <= StIdle;
            line_q    <= '0;
            beat_q    <= '0;
            wait_q    <= '0;
            buf_q     <= '0;
            err_acc_q <= 1'b0;
            data_q    <= '0;
            ready_q   <= 1'b0;
            err_q     <= 1'b0;
            rd_oor_q  <= 1'b0;
        end else begin
            state_q   <= state_d;
            line_q    <= line_d;
            beat_q    <= beat_d;
            wait_q    <= wait_d;
            buf_q     <= buf_d;
            err_acc_q <= err_acc_d;
            data_q    <= data_d;
            ready_q   <= ready_d;
            err_q     <= err_d;
            if (rd_en) begin
                rd_oor_q <= rd_oor;
            end
        end
    end

    assign mem_ready_o = ready_q;
    assign mem_data_o  = data_q;
    assign mem_err_o   = err_q;
    assign busy_o      = state_q != StIdle;

endmodule

// File: tb/tb_icache_mem_responder.sv
// Directed bench: expected lines are queued as requests are driven and
// compared, with their due cycle, whenever a ready pulse appears.
module tb_icache_mem_responder;

    logic         clk = 1'b0;
    logic         rst = 1'b1;
    logic         req = 1'b0;
    logic         req0 = 1'b0;
    logic [31:0]  addr = '0;
    logic         ld_we = 1'b0;
    logic [31:0]  ld_addr = '0;
    logic [31:0]  ld_data = '0;
    logic         rdy2, err2, busy2, rdy0, err0, busy0;
    logic [127:0] data2, data0;

    int cyc = 0;
    int checks = 0;
    int errors = 0;

    typedef struct packed {
        logic [127:0] data;
        logic         err;
        logic [31:0]  due;
    } exp_t;

    exp_t sb2[$];
    exp_t sb0[$];
    exp_t e2, e0;

    localparam logic [127:0] LineA = 128'h000000A3_000000A2_000000A1_000000A0;
    localparam logic [127:0] LineB = 128'h000000B3_000000B2_000000B1_000000B0;
    localparam logic [127:0] LineC = 128'h000000C3_000000C2_000000C1_000000C0;
    localparam logic [127:0] LineD = 128'h000000A3_000000A2_0000BEEF_000000A0;
    localparam logic [127:0] LineP = 128'h00000000_00000000_000000C1_000000C0;

    icache_mem_responder #(
        .MEM_WORDS(4096),
        .LATENCY  (2)
    ) u_dut (
        .clk               (clk),
        .rst               (rst),
        .Icache_valid_req_i(req),
        .Icache_addr_i     (addr),
        .mem_ready_o       (rdy2),
        .mem_data_o        (data2),
        .mem_err_o         (err2),
        .ld_we_i           (ld_we),
        .ld_addr_i         (ld_addr),
        .ld_data_i         (ld_data),
        .busy_o            (busy2)
    );

    // Zero-latency instance with a store two words short of a line boundary.
    icache_mem_responder #(
        .MEM_WORDS(4094),
        .LATENCY  (0)
    ) u_dut0 (
        .clk               (clk),
        .rst               (rst),
        .Icache_valid_req_i(req0),
        .Icache_addr_i     (addr),
        .mem_ready_o       (rdy0),
        .mem_data_o        (data0),
        .mem_err_o         (err0),
        .ld_we_i           (ld_we),
        .ld_addr_i         (ld_addr),
        .ld_data_i         (ld_data),
        .busy_o            (busy0)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string tag, input logic [127:0] got, input logic [127:0] exp);
        checks++;
        assert (got === exp) else begin
            errors++;
            $error("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    always @(negedge clk) begin
        if (rdy2) begin
            chk("lat2_ready_expected", 128'(sb2.size() != 0), 128'd1);
            if (sb2.size() != 0) begin
                e2 = sb2.pop_front();
                chk("lat2_ready_cycle", 128'(cyc), 128'(e2.due));
                chk("lat2_data", data2, e2.data);
                chk("lat2_err", 128'(err2), 128'(e2.err));
            end
        end
    end

    always @(negedge clk) begin
        if (rdy0) begin
            chk("lat0_ready_expected", 128'(sb0.size() != 0), 128'd1);
            if (sb0.size() != 0) begin
                e0 = sb0.pop_front();
                chk("lat0_ready_cycle", 128'(cyc), 128'(e0.due));
                chk("lat0_data", data0, e0.data);
                chk("lat0_err", 128'(err0), 128'(e0.err));
            end
        end
    end

    task automatic load(input logic [31:0] a, input logic [31:0] d);
        @(negedge clk);
        ld_we   = 1'b1;
        ld_addr = a;
        ld_data = d;
        @(negedge clk);
        ld_we   = 1'b0;
    endtask

    // Capture edge is the next posedge; ready is due LATENCY+4 edges after it.
    task automatic request(input bit lat0, input logic [31:0] a, input bit expect_it,
                           input logic [127:0] d, input logic e);
        exp_t x;
        @(negedge clk);
        if (lat0) req0 = 1'b1;
        else req = 1'b1;
        addr   = a;
        x.data = d;
        x.err  = e;
        x.due  = 32'(cyc + (lat0 ? 5 : 7));
        if (expect_it) begin
            if (lat0) sb0.push_back(x);
            else sb2.push_back(x);
        end
        @(negedge clk);
        req  = 1'b0;
        req0 = 1'b0;
    endtask

    task automatic drain(input string tag);
        int n = 0;
        while ((sb2.size() != 0 || sb0.size() != 0) && n < 40) begin
            @(negedge clk);
            n++;
        end
        chk(tag, 128'(sb2.size() + sb0.size()), 128'd0);
        repeat (3) @(negedge clk);
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1);
    end

    initial begin
        repeat (2) @(negedge clk);
        chk("rst_data", data2, 128'd0);
        chk("rst_ready", 128'(rdy2), 128'd0);
        chk("rst_err", 128'(err2), 128'd0);
        chk("rst_busy", 128'(busy2), 128'd0);
        chk("rst_data_lat0", data0, 128'd0);
        rst = 1'b0;

        for (int i = 0; i < 4; i++) begin
            load(32'h10 + 32'(4 * i), 32'hA0 + 32'(i));
            load(32'h20 + 32'(4 * i), 32'hB0 + 32'(i));
            load(32'h3FF0 + 32'(4 * i), 32'hC0 + 32'(i));
        end

        // Basic fill; data must hold after the pulse.
        request(1'b0, 32'h0000_0014, 1'b1, LineA, 1'b0);
        chk("busy_after_capture", 128'(busy2), 128'd1);
        drain("fill_drained");
        chk("fill_data_held", data2, LineA);
        chk("fill_idle_busy", 128'(busy2), 128'd0);

        request(1'b1, 32'h0000_0014, 1'b1, LineA, 1'b0);
        drain("lat0_drained");

        // Abort two cycles in: only the second line is returned.
        request(1'b0, 32'h0000_0010, 1'b0, LineA, 1'b0);
        request(1'b0, 32'h0000_0020, 1'b1, LineB, 1'b0);
        drain("abort_drained");

        // Restart on the beat-3 edge of line 0x20 suppresses its pulse.
        request(1'b0, 32'h0000_0020, 1'b0, LineB, 1'b0);
        repeat (4) @(negedge clk);
        request(1'b0, 32'h0000_0010, 1'b1, LineA, 1'b0);
        drain("restart_beat3_drained");

        // Reset two edges into FETCH (during beat 2).
        request(1'b0, 32'h0000_0010, 1'b0, LineA, 1'b0);
        repeat (4) @(negedge clk);
        rst = 1'b1;
        #1;
        chk("midrst_data", data2, 128'd0);
        chk("midrst_ready", 128'(rdy2), 128'd0);
        chk("midrst_err", 128'(err2), 128'd0);
        chk("midrst_busy", 128'(busy2), 128'd0);
        @(negedge clk);
        rst = 1'b0;
        repeat (12) @(negedge clk);
        request(1'b0, 32'h0000_0010, 1'b1, LineA, 1'b0);
        drain("after_rst_drained");

        // Range handling.
        request(1'b0, 32'h0000_3FF8, 1'b1, LineC, 1'b0);
        drain("top_line_drained");
        request(1'b0, 32'h0000_4000, 1'b1, 128'd0, 1'b1);
        drain("oor_line_drained");
        request(1'b0, 32'hFFFF_FFF4, 1'b1, 128'd0, 1'b1);
        drain("high_addr_drained");
        request(1'b1, 32'h0000_3FF8, 1'b1, LineP, 1'b1);
        drain("partial_oor_drained");

        // Loader write to word 0x14 while beat 1 of line 0x10 is read.
        request(1'b0, 32'h0000_0010, 1'b1, LineA, 1'b0);
        @(negedge clk);
        @(negedge clk);
        ld_we   = 1'b1;
        ld_addr = 32'h0000_0014;
        ld_data = 32'h0000_BEEF;
        @(negedge clk);
        @(negedge clk);
        ld_we   = 1'b0;
        drain("collision_drained");
        request(1'b0, 32'h0000_0010, 1'b1, LineD, 1'b0);
        drain("rerequest_drained");

        repeat (10) @(negedge clk);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
